// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- serial-to-parallel UART receiver.
//
// Frame: 1 start bit (0), DATA_BITS data bits LSB first, 1 stop bit (1).
// The start edge is found on the synchronized line. The start bit is checked
// at its mid-point, and each later bit is sampled one bit period after that.
//
// Parameters
//   CLK_FREQ   system clock in Hz
//   BAUD_RATE  line rate in baud
//   DATA_BITS  data bits per frame (1..15)
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   rx         serial line, asynchronous to clk, idle high
//   rx_data    last correctly framed word, holds between frames
//   rx_valid   one-cycle pulse when rx_data is updated
//   rx_busy    high whenever the receiver is not idle
//   frame_err  one-cycle pulse when the sampled stop bit is 0
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 frame_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;

  localparam logic [15:0] CPB_M1   = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_M1  = 16'(HALF_BIT - 1);
  localparam logic [3:0]  LAST_IDX = 4'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e                 state_q,     state_d;
  logic                   sync1_q,     sync1_d;
  logic                   rx_s_q,      rx_s_d;
  logic                   rx_prev_q,   rx_prev_d;
  // Marks which synchronizer stages hold real line samples rather than their
  // reset value of 1. Without it, a line that is already low when reset is
  // released would look like a 1->0 edge and start a phantom frame.
  logic [2:0]             vld_pipe_q,  vld_pipe_d;
  logic [15:0]            cnt_q,       cnt_d;
  logic [3:0]             idx_q,       idx_d;
  logic [DATA_BITS-1:0]   shift_q,     shift_d;
  logic [DATA_BITS-1:0]   rx_data_q,   rx_data_d;
  logic                   rx_valid_q,  rx_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   fall;

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  // A registered state decode: rises the cycle after the edge is seen and
  // drops on the same edge that raises rx_valid / frame_err.
  assign rx_busy   = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    sync1_d    = rx;
    rx_s_d     = sync1_q;
    rx_prev_d  = rx_s_q;
    vld_pipe_d = {vld_pipe_q[1:0], 1'b1};

    fall = vld_pipe_q[2] & rx_prev_q & ~rx_s_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (fall) state_d = START;
      end

      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          // A line that is back high at the mid-point was a glitch.
          state_d = rx_s_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      DATA: begin
        if (cnt_q == CPB_M1) begin
          cnt_d = '0;
          for (int i = 0; i < DATA_BITS; i++) begin
            if (idx_q == 4'(i)) shift_d[i] = rx_s_q;
          end
          idx_d = idx_q + 4'd1;
          if (idx_q == LAST_IDX) state_d = STOP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      STOP: begin
        if (cnt_q == CPB_M1) begin
          cnt_d = '0;
          idx_d = '0;
          if (rx_s_q) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          // Leaving at the stop-bit mid-point gives half a bit of slack, so
          // a start bit that follows with no idle time is still caught.
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_prev_q   <= 1'b1;
      vld_pipe_q  <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      rx_s_q      <= rx_s_d;
      rx_prev_q   <= rx_prev_d;
      vld_pipe_q  <= vld_pipe_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx at 16 clocks per bit.
// A serial driver emits frames. For each frame it queues the event the
// receiver must produce (word or framing error) and the cycle at which the
// pulse is due. A compare process matches every output pulse against that
// queue and checks rx_data against the last good word on every cycle.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
  localparam int DB   = 8;
  // Pin fall to pulse: 2 sync + 1 edge detect + half bit + data and stop bits.
  localparam int LAT  = 2 + 1 + HALF + (DB + 1) * CPB;

  typedef struct {
    logic       err;
    logic [7:0] data;
    int         due;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx = 1'b1;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          rx_busy;
  logic          frame_err;

  int   cyc = 0;
  int   n_tot = 0;
  int   n_pass = 0;
  exp_t exp_q[$];
  logic [7:0] model_data = 8'h00;
  logic prev_pulse = 1'b0;

  uart_rx #(.CLK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(DB)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_busy(rx_busy),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tot++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, want, cyc);
  endtask

  // Per-cycle comparison against the frame model.
  always @(negedge clk) begin
    logic pulse;
    exp_t e;
    if (rst_n) begin
      pulse = rx_valid | frame_err;
      if (rx_valid && frame_err) chk("valid_and_err", 1, 0);
      if (pulse && prev_pulse) chk("back_to_back_pulse", 1, 0);
      if (pulse) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {30'd0, rx_valid, frame_err}, 0);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_kind_valid", rx_valid, !e.err);
          chk("busy_at_pulse", rx_busy, 0);
          n_tot++;
          if (cyc >= e.due - 1 && cyc <= e.due + 1) n_pass++;
          else $display("FAIL latency: pulse at %0d, expected %0d +-1", cyc, e.due);
          if (!e.err) model_data = e.data;
        end
      end
      chk("rx_data", rx_data, model_data);
      prev_pulse = pulse;
    end else begin
      prev_pulse = 1'b0;
    end
  end

  // Caller is aligned to a negedge; returns aligned to a negedge.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    exp_t e;
    e.err = !stop_bit; e.data = d; e.due = cyc + LAT;
    exp_q.push_back(e);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      rx = d[i];
      if (i == 0) begin
        repeat (HALF) @(negedge clk);
        chk("busy_mid_frame", rx_busy, 1);
        repeat (CPB - HALF) @(negedge clk);
      end else begin
        repeat (CPB) @(negedge clk);
      end
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("pending_events", exp_q.size(), 0);
  endtask

  initial begin
    logic [7:0] b;
    // Reset state.
    #1;
    chk("reset_rx_data", rx_data, 0);
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_rx_busy", rx_busy, 0);
    chk("reset_frame_err", frame_err, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(10);
    chk("idle_busy", rx_busy, 0);

    // Single clean frame.
    send_frame(8'hA5, 1'b1);
    idle(10);
    drain();
    chk("literal_a5", rx_data, 8'hA5);
    chk("busy_after_a5", rx_busy, 0);

    // Back-to-back frames, no idle gap.
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h3C, 1'b1);
    idle(10);
    drain();
    chk("literal_3c", rx_data, 8'h3C);

    // 4-cycle low glitch on an idle line.
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    chk("busy_during_glitch", rx_busy, 1);
    repeat (20) @(negedge clk);
    chk("busy_after_glitch", rx_busy, 0);
    idle(CPB * 12);

    // Stop bit driven low, then the line stays low.
    send_frame(8'h5A, 1'b0);
    rx = 1'b0;
    repeat (100) @(negedge clk);
    chk("busy_line_low", rx_busy, 0);
    drain();
    chk("data_kept_after_err", rx_data, 8'h3C);
    idle(20);
    send_frame(8'hC3, 1'b1);
    idle(10);
    drain();

    // Reset in the middle of data bit 4.
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = ~rx;
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
    repeat (HALF) @(negedge clk);
    chk("busy_before_reset", rx_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_rx_data", rx_data, 0);
    chk("mid_reset_rx_valid", rx_valid, 0);
    chk("mid_reset_rx_busy", rx_busy, 0);
    chk("mid_reset_frame_err", frame_err, 0);
    exp_q.delete();
    model_data = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(10);
    send_frame(8'h81, 1'b1);
    idle(10);
    drain();
    chk("literal_81", rx_data, 8'h81);

    // Loopback-style random traffic with random idle gaps (some zero).
    for (int n = 0; n < 256; n++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1);
      idle($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 20));
    end
    idle(10);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  // Hard stop in case a wait above never completes.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("%0d/%0d checks passed", n_pass, n_tot + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver: the receive end of the link driven by the team's UART transmitter. Detects a start bit on the asynchronous `rx` line, samples each bit at mid-bit, checks the stop bit and presents one data word per frame with a single-cycle valid strobe. Frame format is fixed: 1 start bit (0), `DATA_BITS` data bits LSB first, 1 stop bit (1). This matches the transmitter configured with `FRAME_BITS = DATA_BITS + 2` and `frame_data = {1'b1, data, 1'b0}`.

## Interface
- `CLK_FREQ`, 50_000_000, system clock frequency in Hz.
- `BAUD_RATE`, 9600, line baud rate.
- `DATA_BITS`, 8, data bits per frame; legal range 1..15.

- `clk`  input  1  system clock; all logic on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `rx`  input  1  serial line, asynchronous to `clk`, idle high.
- `rx_data`  output  DATA_BITS  last correctly framed word; holds between frames.
- `rx_valid`  output  1  one-cycle pulse when `rx_data` is updated.
- `rx_busy`  output  1  high while a frame is being received (any state except IDLE).
- `frame_err`  output  1  one-cycle pulse when the sampled stop bit is 0.

## Operation
- `CLKS_PER_BIT = CLK_FREQ / BAUD_RATE`, integer division. `HALF_BIT = CLKS_PER_BIT / 2`. Legal range of `CLKS_PER_BIT`: 4..65535. The clock counter is 16 bits. The bit index is 4 bits.
- Input synchronizer: two flops on `rx`, reset to 1. A third flop, `rx_prev`, holds the previous synchronized value for edge detection. All decisions use the synchronized value `rx_s`.
- States: IDLE, START, DATA, STOP.
- IDLE: counter = 0, index = 0. On a falling edge (`rx_prev`=1, `rx_s`=0), go to START. A line held low (break, or a low line after reset release) never triggers a start; a 1 must be seen first.
- START: count up. At count = HALF_BIT-1, check `rx_s`:
  - 0: go to DATA with counter = 0.
  - 1: treat as a glitch and return to IDLE. No outputs pulse.
- DATA: count up. At count = CLKS_PER_BIT-1, sample `rx_s` into shift-register bit `index` (LSB first), clear the counter and increment the index. After sampling index DATA_BITS-1, go to STOP.
- STOP: count up. At count = CLKS_PER_BIT-1, sample `rx_s`:
  - 1: load `rx_data` from the shift register, pulse `rx_valid` for one cycle, go to IDLE.
  - 0: pulse `frame_err` for one cycle, leave `rx_data` unchanged, go to IDLE.
- `rx_valid` and `frame_err` are mutually exclusive and never high for two consecutive cycles.
- No flow control. Software or downstream logic must capture `rx_data` before the next frame completes. Back-to-back frames with no idle time are accepted because the STOP→IDLE return happens at stop-bit mid-point.

## Timing
- Reset values (asynchronous on `rst_n` low): `rx_data`=0, `rx_valid`=0, `rx_busy`=0, `frame_err`=0, state IDLE, counters 0, synchronizer and `rx_prev` = 1.
- Reset asserted mid-frame aborts the frame immediately; no pulse is produced.
- Synchronizer latency is 2 cycles from an `rx` pin change to `rx_s`.
- `rx_busy` rises the cycle after the falling edge is detected on `rx_s`. It falls in the same cycle that `rx_valid` or `frame_err` is asserted.
- Frame latency, measured from the start-bit falling edge at the pin to `rx_valid` high: 2 + 1 + HALF_BIT + (DATA_BITS+1)·CLKS_PER_BIT cycles. A tolerance of ±1 cycle is allowed to the bench.
- Sample points fall at HALF_BIT + k·CLKS_PER_BIT after the detected edge, which is nominally mid-bit.

## Test plan
All scenarios use `CLK_FREQ`=16, `BAUD_RATE`=1, giving CLKS_PER_BIT=16.
- Reset release with `rx` high, then send 0xA5 as an 8N1 frame -> exactly one `rx_valid` pulse with `rx_data`=0xA5 and `frame_err` never high; `rx_busy` high only during the frame.
- Send 0x00, 0xFF and 0x3C back-to-back with no idle gap -> three `rx_valid` pulses carrying 0x00, 0xFF, 0x3C in order.
- Low glitch of 4 cycles on an idle line -> return to IDLE at the mid-start check, with no `rx_valid` and no `frame_err`.
- Send 0x5A with the stop bit driven 0 -> one `frame_err` pulse, no `rx_valid`, and `rx_data` keeps its previous value. Hold the line low for a further 100 cycles -> no new frame starts until the line goes high and then falls again.
- Assert `rst_n` low in the middle of data bit 4 -> all outputs read 0 immediately. After release, a clean 0x81 frame -> `rx_valid` with `rx_data`=0x81.
- Loopback with the team's UART transmitter (FRAME_BITS=10) for 256 random bytes -> every byte is received intact and `frame_err` stays 0.
